// File: rtl/bram_fifo_rd_pkg.sv
// Shared definitions for the BRAM FIFO read side: pointer width helper and output buffer state codes.
// Configuration macro used by the top: BRAM_FIFO_RD_LEVEL_EN (adds the registered level output).
package bram_fifo_rd_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int a);
    return a + 1;
  endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry output buffer for the BRAM read side; head entry drives the stream directly from registers.
module bram_rd_skid
  import bram_fifo_rd_pkg::*;
#(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [DATA-1:0] push_data,
  input  logic            pop,
  output logic [DATA-1:0] head_data,
  output logic            head_valid,
  output logic [1:0]      entries
);

  logic [1:0]      state;
  logic [DATA-1:0] head, second;

  assign head_data  = head;
  assign head_valid = (state != ST_EMPTY);
  // State encoding doubles as the entry count.
  assign entries    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      head   <= '0;
      second <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) begin
          head  <= push_data;
          state <= ST_ONE;
        end
        ST_ONE: case ({push, pop})
          2'b11: head <= push_data;
          2'b10: begin
            second <= push_data;
            state  <= ST_TWO;
          end
          2'b01: state <= ST_EMPTY;
          default: ;
        endcase
        ST_TWO: if (pop) begin
          head <= second;
          if (push) second <= push_data;
          else      state  <= ST_ONE;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_rd.sv
// Read-side FIFO controller: drives BRAM port B, absorbs the 1-cycle read latency, emits a valid/ready stream.
// Optional macro BRAM_FIFO_RD_LEVEL_EN adds a registered, saturating fill-level output.
module bram_fifo_rd
  import bram_fifo_rd_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ADDR:0]   wr_ptr,
  output logic [ADDR:0]   rd_ptr,
  output logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_read,
  input  logic            flush,
  output logic [DATA-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
`ifdef BRAM_FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR:0]   level
`endif
);

  localparam int PW = ptr_w(ADDR);

  logic [PW-1:0] ptr_q;
  logic          inflight;
  logic [1:0]    entries;
  logic          empty, pop, issue;
  logic [2:0]    occ;

  assign rd_ptr = ptr_q;
  assign b_addr = ptr_q[ADDR-1:0];
  assign empty  = (ptr_q == wr_ptr);
  assign pop    = out_valid & out_ready;
  assign occ    = {1'b0, entries} + {2'b0, inflight};
  // A read may only launch if its word is guaranteed a buffer slot on capture.
  assign issue  = ~empty & ~flush & (occ < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      ptr_q    <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (issue) ptr_q <= ptr_q + 1'b1;
      inflight <= issue;
    end
  end

  bram_rd_skid #(.DATA(DATA)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (inflight & ~flush),
    .push_data (b_read),
    .pop       (pop & ~flush),
    .head_data (out_data),
    .head_valid(out_valid),
    .entries   (entries)
  );

`ifdef BRAM_FIFO_RD_LEVEL_EN
  localparam logic [ADDR+1:0] DEPTH = (ADDR+2)'(1) << ADDR;

  logic [ADDR:0]   diff;
  logic [ADDR+1:0] sum;
  logic [ADDR:0]   level_q;

  assign diff  = wr_ptr - ptr_q;
  assign sum   = {1'b0, diff} + {{ADDR{1'b0}}, entries} + {{(ADDR+1){1'b0}}, inflight};
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (reset || flush) level_q <= '0;
    else if (sum > DEPTH) level_q <= DEPTH[ADDR:0];
    else level_q <= sum[ADDR:0];
  end
`endif

endmodule

// File: tb/tb_bram_fifo_rd.sv
// Scoreboard bench for bram_fifo_rd: behavioural RAM + writer, randomized stream back-pressure.
module tb_bram_fifo_rd;
  localparam int DATA  = 8;
  localparam int ADDR  = 10;
  localparam int DEPTH = 1 << ADDR;

  logic            clk = 0;
  logic            reset = 1;
  logic [ADDR:0]   wr_ptr = '0;
  logic [ADDR:0]   rd_ptr;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_read = '0;
  logic            flush = 0;
  logic [DATA-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 0;
`ifdef BRAM_FIFO_RD_LEVEL_EN
  logic [ADDR:0]   level;
`endif

  bram_fifo_rd #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .b_addr   (b_addr),
    .b_read   (b_read),
    .flush    (flush),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BRAM_FIFO_RD_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA-1:0] mem [DEPTH];
  always @(posedge clk) b_read <= mem[b_addr];

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  logic [DATA-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer model: one word per call, caller owns timing.
  function automatic bit has_space();
    logic [ADDR:0] d;
    d = wr_ptr - rd_ptr;
    return d < (ADDR+1)'(DEPTH);
  endfunction

  function automatic void do_write(input logic [DATA-1:0] d);
    mem[wr_ptr[ADDR-1:0]] = d;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(d);
  endfunction

  // Monitor: every accepted transfer must match the oldest expected word; held data must not change.
  initial begin
    logic            hold_prev;
    logic [DATA-1:0] hold_data;
    logic [DATA-1:0] e;
    hold_prev = 0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && !flush) begin
        if (hold_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(hold_data));
        end
        if (out_valid && out_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("stream_data", 32'(out_data), 32'(e));
          end
        end
      end
      hold_prev = !reset && !flush && out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; wr_ptr = '0; out_ready = 0; flush = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while (n < bound && !(exp_q.size() == 0 && !out_valid)) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d left expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps, written, n;

    // Reset state held with an idle writer.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
      check("rst_b_addr", 32'(b_addr), 32'd0);
    end
`ifdef BRAM_FIFO_RD_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif

    // First-word latency: visible two cycles after the write.
    @(posedge clk); #1;
    out_ready = 1;
    do_write(8'hA5);
    @(negedge clk); check("lat_n0", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_data", 32'(out_data), 32'hA5);
    check("lat_rd_ptr", 32'(rd_ptr), 32'd1);
    drain("lat", 20);

    // Full-depth burst with back-pressure, then sustained 1 word/cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      do_write(DATA'(i));
    end
    repeat (4) @(posedge clk);
    #1 out_ready = 1;
    gaps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (!out_valid) gaps++;
    end
    check("burst_gaps", 32'(gaps), 32'd0);
    check("burst_rd_ptr", 32'(rd_ptr), 32'h400);
    drain("burst", 20);
    check("burst_left", 32'(exp_q.size()), 32'd0);

    // Random back-pressure over 100 random words.
    do_reset();
    written = 0;
    n = 0;
    while (n < 3000 && (written < 100 || exp_q.size() != 0)) begin
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 1) == 1;
      if (written < 100 && $urandom_range(0, 2) != 0 && has_space()) begin
        do_write(DATA'($urandom));
        written++;
      end
      n++;
    end
    check("rand_left", 32'(exp_q.size()), 32'd0);
    out_ready = 1;
    drain("rand", 20);

    // Pointer wrap across address 0 with the wrap bit set.
    do_reset();
    out_ready = 1;
    written = 0;
    while (written < DEPTH - 2) begin
      @(posedge clk); #1;
      if (has_space()) begin
        do_write(DATA'($urandom));
        written++;
      end
    end
    drain("prewrap", 100);
    check("prewrap_rd_ptr", 32'(rd_ptr), 32'h3FE);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      do_write(DATA'(8'hC0 + i));
    end
    drain("wrap", 50);
    check("wrap_rd_ptr", 32'(rd_ptr), 32'h402);

    // Flush with one word buffered, one in flight and one unread in RAM.
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      do_write(DATA'(8'h30 + i));
    end
    flush = 1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));
`ifdef BRAM_FIFO_RD_LEVEL_EN
    check("flush_level", 32'(level), 32'd0);
`endif
    repeat (3) @(negedge clk);
    check("flush_idle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      do_write(DATA'(8'h51 + i));
      @(posedge clk); #1;
    end
    drain("postflush", 50);
    check("postflush_pops", 32'(pop_cnt > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
